uart_tx_ctrl: RTL and testbench

Serial transmitter for the memory-mapped UART. It takes the byte the CPU writes to the UART_TXD register (0x40000018) and sends it on `txd` as 8N1 frames: one start bit, eight data bits LSB first, one stop bit. A one-entry holding buffer lets software queue a second byte while a frame is in flight. Status is returned through the UART_CON register (0x40000020), and writing UART_CON clears the sticky flags.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 8E1 frames).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    localparam int unsigned CON_DONE = 0;
    localparam int unsigned CON_HOLD = 1;
    localparam int unsigned CON_BUSY = 2;
    localparam int unsigned CON_OVR  = 3;

    localparam logic [31:0] UART_TXD_ADDR = 32'h40000018;
    localparam logic [31:0] UART_CON_ADDR = 32'h40000020;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: wraps every CLKS_PER_BIT cycles, pulses bit_end on the wrap cycle.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (restart || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter with one-entry holding buffer and sticky CON status flags.
// Optional feature macro: UART_TX_PARITY_EN (8E1 instead of 8N1).
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_wdata,
    input  logic       tx_we,
    input  logic       con_clr,
    output logic       txd,
    output logic [3:0] con_status
);

    import uart_pkg::*;

    tx_state_t  state, state_n;
    logic [7:0] shift, shift_n;
    logic [7:0] hold, hold_n;
    logic       hold_full, hold_full_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic       done, done_n;
    logic       ovr, ovr_n;
    logic       busy;
    logic       txd_n;
    logic       load;
    logic [7:0] load_byte;
    logic       direct_start;
    logic       bit_end;
`ifdef UART_TX_PARITY_EN
    logic       par, par_n;
`endif

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (load),
        .bit_end (bit_end)
    );

    assign direct_start = (state == IDLE) && !hold_full;

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        bit_idx_n   = bit_idx;
        done_n      = done;
        ovr_n       = ovr;
        load        = 1'b0;
        load_byte   = hold;
        txd_n       = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n       = par;
`endif

        if (con_clr) begin
            done_n = 1'b0;
            ovr_n  = 1'b0;
        end

        case (state)
            IDLE: begin
                if (hold_full) begin
                    load        = 1'b1;
                    hold_full_n = 1'b0;
                end else if (tx_we) begin
                    load      = 1'b1;
                    load_byte = tx_wdata;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n   = {1'b0, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end)
                    state_n = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done_n = 1'b1;
                    if (hold_full) begin
                        load        = 1'b1;
                        hold_full_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            shift_n = load_byte;
            state_n = START;
`ifdef UART_TX_PARITY_EN
            par_n   = ^load_byte;
`endif
        end

        // Uses hold_full_n so a write on the hold-to-shift cycle refills hold instead of overrunning.
        if (tx_we && !direct_start) begin
            if (!hold_full_n) begin
                hold_n      = tx_wdata;
                hold_full_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end

        case (state_n)
            START:  txd_n = 1'b0;
            DATA:   txd_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_n = par_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_idx   <= '0;
            done      <= 1'b0;
            ovr       <= 1'b0;
            busy      <= 1'b0;
            txd       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            bit_idx   <= bit_idx_n;
            done      <= done_n;
            ovr       <= ovr_n;
            busy      <= (state_n != IDLE);
            txd       <= txd_n;
`ifdef UART_TX_PARITY_EN
            par       <= par_n;
`endif
        end
    end

    always_comb begin
        con_status           = '0;
        con_status[CON_DONE] = done;
        con_status[CON_HOLD] = hold_full;
        con_status[CON_BUSY] = busy;
        con_status[CON_OVR]  = ovr;
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame-level reference model plus directed literal checks.
module tb_uart_tx_ctrl;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FL = NB * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_wdata;
    logic       tx_we;
    logic       con_clr;
    logic       txd;
    logic [3:0] con_status;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_wdata   (tx_wdata),
        .tx_we      (tx_we),
        .con_clr    (con_clr),
        .txd        (txd),
        .con_status (con_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the line is a list of bit levels, each held CPB cycles.
    logic        m_active;
    int unsigned m_cyc;
    logic [10:0] m_bits;
    logic [7:0]  m_hold[$];
    logic        m_done, m_ovr, m_wasbusy, m_sd, m_so;
    logic        exp_txd;
    logic [3:0]  exp_con;

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_cyc    = 0;
            m_bits   = '1;
            m_hold.delete();
            m_done   = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            m_wasbusy = m_active;
            m_sd      = 1'b0;
            m_so      = 1'b0;
            if (m_active) begin
                if (m_cyc == FL - 1) begin
                    m_sd = 1'b1;
                    if (m_hold.size() != 0) begin
                        m_bits = frame_of(m_hold.pop_front());
                        m_cyc  = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_cyc++;
                end
            end else if (m_hold.size() != 0) begin
                m_bits    = frame_of(m_hold.pop_front());
                m_cyc     = 0;
                m_active  = 1'b1;
                m_wasbusy = 1'b1;
            end
            if (tx_we) begin
                if (!m_wasbusy) begin
                    m_bits   = frame_of(tx_wdata);
                    m_cyc    = 0;
                    m_active = 1'b1;
                end else if (m_hold.size() == 0) begin
                    m_hold.push_back(tx_wdata);
                end else begin
                    m_so = 1'b1;
                end
            end
            if (con_clr) begin
                m_done = 1'b0;
                m_ovr  = 1'b0;
            end
            if (m_sd) m_done = 1'b1;
            if (m_so) m_ovr  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_txd = m_active ? m_bits[m_cyc / CPB] : 1'b1;
            exp_con = {m_ovr, m_active, (m_hold.size() != 0), m_done};
            check("model_txd", 32'(txd), 32'(exp_txd));
            check("model_con", 32'(con_status), 32'(exp_con));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle write; returns in the cycle after the strobe.
    task automatic write(input logic [7:0] b);
        tx_we    = 1'b1;
        tx_wdata = b;
        step();
        tx_we    = 1'b0;
    endtask

    task automatic clear_flags();
        con_clr = 1'b1;
        step();
        con_clr = 1'b0;
    endtask

    logic        line [0:255];
    logic [10:0] pat55;
    logic [0:7]  seq_a3, seq_0f, seq_e7;

    initial begin
        reset    = 1'b1;
        tx_we    = 1'b0;
        con_clr  = 1'b0;
        tx_wdata = '0;
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_con", 32'(con_status), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Reset in the middle of a frame.
        write(8'hC6);
        repeat (10) step();
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_txd", 32'(txd), 32'd1);
        check("rst_mid_con", 32'(con_status), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // 0x55 frame: alternating levels, each held CPB cycles.
`ifdef UART_TX_PARITY_EN
        pat55 = 11'b10010101010;
`else
        pat55 = 11'b11010101010;
`endif
        write(8'h55);
        check("start_busy", 32'(con_status), 32'b0100);
        for (int unsigned i = 0; i < FL; i++) begin
            check("frame55", 32'(txd), 32'(pat55[i / CPB]));
            step();
        end
        check("done_after_frame", 32'(con_status), 32'b0001);
        clear_flags();
        check("clr_idle", 32'(con_status), 32'd0);

        // 0xA3 then 0x0F eight cycles later, back-to-back on the line.
        seq_a3 = 8'b11000101;
        seq_0f = 8'b11110000;
        write(8'hA3);
        for (int unsigned i = 0; i < 2 * FL + 4; i++) begin
            tx_we    = (i == 7);
            tx_wdata = 8'h0F;
            if (i == 8) check("hold_full", 32'(con_status[1]), 32'd1);
            line[i] = txd;
            step();
        end
        tx_we = 1'b0;
        check("b2b_stop", 32'(line[FL - 1]), 32'd1);
        check("b2b_start", 32'(line[FL]), 32'd0);
        for (int unsigned j = 0; j < 8; j++) begin
            check("data_a3", 32'(line[CPB * (1 + j) + CPB / 2]), 32'(seq_a3[j]));
            check("data_0f", 32'(line[FL + CPB * (1 + j) + CPB / 2]), 32'(seq_0f[j]));
        end
        clear_flags();

        // Three writes while busy: third is dropped.
        write(8'h11);
        for (int unsigned i = 0; i < 2 * FL + 16; i++) begin
            tx_we    = (i == 1) || (i == 3);
            tx_wdata = (i == 1) ? 8'h22 : 8'h33;
            if (i == 5) check("ovr_set", 32'(con_status[3]), 32'd1);
            if (i == 2 * FL - 1) check("busy_last", 32'(con_status[2]), 32'd1);
            if (i == 2 * FL) check("busy_end", 32'(con_status[2]), 32'd0);
            if (i == 2 * FL + 15) check("line_idle", 32'(txd), 32'd1);
            step();
        end
        tx_we = 1'b0;
        clear_flags();

        // con_clr on the tx_done set cycle, then one cycle later.
        write(8'h5A);
        for (int unsigned i = 0; i < FL + 3; i++) begin
            con_clr = (i == FL - 1) || (i == FL);
            if (i == FL) check("clr_vs_set", 32'(con_status[0]), 32'd1);
            if (i == FL + 1) check("clr_after", 32'(con_status[0]), 32'd0);
            step();
        end
        con_clr = 1'b0;
        clear_flags();

        // Write on the hold-to-shift cycle becomes the third frame.
        seq_e7 = 8'b11100111;
        write(8'h81);
        for (int unsigned i = 0; i < 3 * FL + 4; i++) begin
            tx_we    = (i == 1) || (i == FL - 1);
            tx_wdata = (i == 1) ? 8'h42 : 8'hE7;
            if (i == FL) begin
                check("xfer_no_ovr", 32'(con_status[3]), 32'd0);
                check("xfer_held", 32'(con_status[1]), 32'd1);
            end
            line[i] = txd;
            step();
        end
        tx_we = 1'b0;
        check("third_start", 32'(line[2 * FL]), 32'd0);
        for (int unsigned j = 0; j < 8; j++)
            check("data_e7", 32'(line[2 * FL + CPB * (1 + j) + CPB / 2]), 32'(seq_e7[j]));
        clear_flags();

`ifdef UART_TX_PARITY_EN
        write(8'h07);
        for (int unsigned i = 0; i < FL + 2; i++) begin
            line[i] = txd;
            step();
        end
        check("parity_07", 32'(line[9 * CPB + CPB / 2]), 32'd1);
        check("stop_07", 32'(line[10 * CPB + CPB / 2]), 32'd1);
        write(8'h03);
        for (int unsigned i = 0; i < FL + 2; i++) begin
            line[i] = txd;
            step();
        end
        check("parity_03", 32'(line[9 * CPB + CPB / 2]), 32'd0);
        clear_flags();
`endif

        // Randomized traffic against the model, with one asynchronous reset.
        for (int unsigned i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                tx_we   = 1'b0;
                con_clr = 1'b0;
                #2;
                reset = 1'b1;
                step();
                step();
                reset = 1'b0;
            end
            tx_we    = ($urandom_range(0, 24) == 0);
            tx_wdata = 8'($urandom);
            con_clr  = ($urandom_range(0, 39) == 0);
            step();
        end
        tx_we   = 1'b0;
        con_clr = 1'b0;
        repeat (2 * FL + 4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
